// File: rtl/open_drain_pullup.sv
// Clocked pull-up model for a shared open-drain line: wired-AND of drive-low requests,
// finite rise time, edge pulses, contention and long-low flags. Optional stats: PULLUP_STATS_EN.
module open_drain_pullup #(
    parameter int N_DRV       = 4,
    parameter int RISE_CYCLES = 3,
    parameter int HOLD_CYCLES = 100
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [N_DRV-1:0] drv_low_i,
    output logic             line_o,
    output logic             rise_pulse_o,
    output logic             fall_pulse_o,
    output logic             multi_low_o,
    output logic             held_low_o,
`ifdef PULLUP_STATS_EN
    output logic [15:0]      fall_count_o,
    output logic [15:0]      max_low_o,
`endif
    output logic [N_DRV-1:0] low_owner_o
);

    localparam int RW = $clog2(RISE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [RW-1:0] RISE_LAST = RW'(RISE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

    logic             any_low;
    logic [4:0]       pop_count;
    logic             line_q, line_d;
    logic [RW-1:0]    rise_cnt_q, rise_cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             multi_q, multi_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic             held_q, held_d;
    logic [N_DRV-1:0] owner_q;

    // Wired-AND resolution: any single driver pulls the line low immediately,
    // while release has to survive RISE_CYCLES uninterrupted samples.
    always_comb begin
        any_low    = |drv_low_i;
        line_d     = line_q;
        rise_cnt_d = rise_cnt_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        if (any_low) begin
            line_d     = 1'b0;
            rise_cnt_d = '0;
            fall_d     = line_q;
        end else if (!line_q) begin
            if (rise_cnt_q == RISE_LAST) begin
                line_d     = 1'b1;
                rise_d     = 1'b1;
                rise_cnt_d = '0;
            end else begin
                rise_cnt_d = rise_cnt_q + 1'b1;
            end
        end else begin
            rise_cnt_d = '0;
        end
    end

    // Contention is legal on open-drain, so this is only reported.
    always_comb begin
        pop_count = '0;
        for (int i = 0; i < N_DRV; i++) begin
            pop_count = pop_count + 5'(drv_low_i[i]);
        end
        multi_d = (pop_count >= 5'd2);
    end

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (line_d) begin
            hold_cnt_d = '0;
        end else if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
        held_d = (hold_cnt_d == HOLD_MAX);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            line_q     <= 1'b1;
            rise_cnt_q <= '0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            multi_q    <= 1'b0;
            hold_cnt_q <= '0;
            held_q     <= 1'b0;
            owner_q    <= '0;
        end else begin
            line_q     <= line_d;
            rise_cnt_q <= rise_cnt_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            multi_q    <= multi_d;
            hold_cnt_q <= hold_cnt_d;
            held_q     <= held_d;
            owner_q    <= drv_low_i;
        end
    end

    assign line_o       = line_q;
    assign rise_pulse_o = rise_q;
    assign fall_pulse_o = fall_q;
    assign multi_low_o  = multi_q;
    assign held_low_o   = held_q;
    assign low_owner_o  = owner_q;

`ifdef PULLUP_STATS_EN
    logic [15:0] fall_count_q, fall_count_d;
    logic [15:0] low_len_q, low_len_d;
    logic [15:0] max_low_q, max_low_d;

    // low_len tracks the current low period; it is folded into max_low on the rising edge.
    always_comb begin
        fall_count_d = fall_count_q;
        if (fall_d && fall_count_q != 16'hFFFF) begin
            fall_count_d = fall_count_q + 16'd1;
        end
        low_len_d = low_len_q;
        if (line_d) begin
            low_len_d = '0;
        end else if (low_len_q != 16'hFFFF) begin
            low_len_d = low_len_q + 16'd1;
        end
        max_low_d = max_low_q;
        if (rise_d && low_len_q > max_low_q) begin
            max_low_d = low_len_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fall_count_q <= '0;
            low_len_q    <= '0;
            max_low_q    <= '0;
        end else begin
            fall_count_q <= fall_count_d;
            low_len_q    <= low_len_d;
            max_low_q    <= max_low_d;
        end
    end

    assign fall_count_o = fall_count_q;
    assign max_low_o    = max_low_q;
`endif

endmodule

// File: tb/tb_open_drain_pullup.sv
// Randomised and directed bench for open_drain_pullup against a streak-based line model.
module tb_open_drain_pullup;

    localparam int N    = 4;
    localparam int RISE = 3;
    localparam int HOLD = 100;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] drvLow = '0;
    logic         line, risePulse, fallPulse, multiLow, heldLow;
    logic [N-1:0] lowOwner;
`ifdef PULLUP_STATS_EN
    logic [15:0]  fallCount, maxLow;
`endif

    int nCompared = 0;
    int nMismatched = 0;

    // Reference model: line is high once RISE consecutive released samples have accumulated.
    int           relStreak;
    int           lowStreak;
    logic         mLine, mRise, mFall, mMulti, mHeld;
    logic [N-1:0] mOwner;
    int           mFallCnt, mMaxLow;

    open_drain_pullup #(.N_DRV(N), .RISE_CYCLES(RISE), .HOLD_CYCLES(HOLD)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .drv_low_i    (drvLow),
        .line_o       (line),
        .rise_pulse_o (risePulse),
        .fall_pulse_o (fallPulse),
        .multi_low_o  (multiLow),
        .held_low_o   (heldLow),
`ifdef PULLUP_STATS_EN
        .fall_count_o (fallCount),
        .max_low_o    (maxLow),
`endif
        .low_owner_o  (lowOwner)
    );

    always #5 clk = ~clk;

    // Drive one sample, advance one edge, update the model and settle just after the edge.
    task automatic step(input logic [N-1:0] drv, input logic rst);
        logic prevLine;
        drvLow = drv;
        reset  = rst;
        @(posedge clk);
        if (rst) begin
            relStreak = RISE; lowStreak = 0;
            mLine = 1'b1; mRise = 1'b0; mFall = 1'b0; mMulti = 1'b0; mHeld = 1'b0;
            mOwner = '0; mFallCnt = 0; mMaxLow = 0;
        end else begin
            prevLine  = mLine;
            relStreak = (drv != 0) ? 0 : ((relStreak >= RISE) ? RISE : relStreak + 1);
            mLine  = (relStreak >= RISE);
            mRise  = mLine && !prevLine;
            mFall  = !mLine && prevLine;
            mMulti = ($countones(drv) >= 2);
            mOwner = drv;
            if (mFall && mFallCnt < 65535) mFallCnt++;
            if (mRise && lowStreak > mMaxLow) mMaxLow = (lowStreak > 65535) ? 65535 : lowStreak;
            lowStreak = mLine ? 0 : lowStreak + 1;
            mHeld  = (lowStreak >= HOLD);
        end
        #1;
    endtask

    task automatic test_reset();
        step(4'b0001, 1'b1);
        step(4'b0011, 1'b1);
        nCompared++;
        if ({line, risePulse, fallPulse, multiLow, heldLow, lowOwner} !== {5'b10000, 4'b0000}) begin
            nMismatched++;
            $display("[TB] FAIL reset_state got=%b want=%b",
                     {line, risePulse, fallPulse, multiLow, heldLow, lowOwner}, 9'b100000000);
        end
        step(4'b0000, 1'b0);
        nCompared++;
        if ({line, risePulse, fallPulse, multiLow, heldLow, lowOwner} !== {5'b10000, 4'b0000}) begin
            nMismatched++;
            $display("[TB] FAIL after_reset got=%b want=%b",
                     {line, risePulse, fallPulse, multiLow, heldLow, lowOwner}, 9'b100000000);
        end
    endtask

    task automatic test_single_pulse();
        step(4'b0100, 1'b0);
        nCompared++;
        if ({line, fallPulse, risePulse} !== 3'b010) begin
            nMismatched++;
            $display("[TB] FAIL fall_edge got=%b want=010", {line, fallPulse, risePulse});
        end
        for (int i = 1; i <= RISE; i++) begin
            step(4'b0000, 1'b0);
            nCompared++;
            if ({line, risePulse, fallPulse} !== ((i == RISE) ? 3'b110 : 3'b000)) begin
                nMismatched++;
                $display("[TB] FAIL rise_latency edge=%0d got=%b want=%b", i,
                         {line, risePulse, fallPulse}, (i == RISE) ? 3'b110 : 3'b000);
            end
        end
        step(4'b0000, 1'b0);
        nCompared++;
        if ({line, risePulse} !== 2'b10) begin
            nMismatched++;
            $display("[TB] FAIL rise_one_cycle got=%b want=10", {line, risePulse});
        end
    endtask

    task automatic test_interrupted_rise();
        step(4'b1000, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0001, 1'b0);
        nCompared++;
        if ({line, risePulse, fallPulse} !== 3'b000) begin
            nMismatched++;
            $display("[TB] FAIL interrupted_rise got=%b want=000", {line, risePulse, fallPulse});
        end
        for (int i = 1; i <= RISE; i++) begin
            step(4'b0000, 1'b0);
            nCompared++;
            if ({line, risePulse} !== ((i == RISE) ? 2'b11 : 2'b00)) begin
                nMismatched++;
                $display("[TB] FAIL restart_rise edge=%0d got=%b want=%b", i,
                         {line, risePulse}, (i == RISE) ? 2'b11 : 2'b00);
            end
        end
    endtask

    task automatic test_multi_low();
        int falls = 0;
        for (int i = 1; i <= 5; i++) begin
            step(4'b0011, 1'b0);
            if (fallPulse) falls++;
            nCompared++;
            if ({multiLow, lowOwner, line} !== {1'b1, 4'b0011, 1'b0}) begin
                nMismatched++;
                $display("[TB] FAIL multi_low cycle=%0d got=%b want=%b", i,
                         {multiLow, lowOwner, line}, 6'b100110);
            end
        end
        nCompared++;
        if (falls !== 1) begin
            nMismatched++;
            $display("[TB] FAIL multi_fall_count got=%0d want=1", falls);
        end
        for (int i = 0; i < RISE; i++) step(4'b0000, 1'b0);
    endtask

    task automatic test_hold();
        for (int i = 1; i <= 150; i++) begin
            step(4'b0100, 1'b0);
            if (i == 99 || i == 100 || i == 150) begin
                nCompared++;
                if (heldLow !== (i >= HOLD)) begin
                    nMismatched++;
                    $display("[TB] FAIL held_low cycle=%0d got=%b want=%b", i, heldLow, i >= HOLD);
                end
            end
        end
        for (int i = 1; i <= RISE; i++) begin
            step(4'b0000, 1'b0);
            nCompared++;
            if ({line, heldLow} !== ((i == RISE) ? 2'b10 : 2'b01)) begin
                nMismatched++;
                $display("[TB] FAIL held_release edge=%0d got=%b want=%b", i,
                         {line, heldLow}, (i == RISE) ? 2'b10 : 2'b01);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] d;
        logic         r;
        for (int i = 0; i < 400; i++) begin
            d = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            r = ($urandom_range(0, 60) == 0);
            step(d, r);
            nCompared++;
            if ({line, risePulse, fallPulse, multiLow, heldLow, lowOwner} !==
                {mLine, mRise, mFall, mMulti, mHeld, mOwner}) begin
                nMismatched++;
                $display("[TB] FAIL random cycle=%0d drv=%b got=%b want=%b", i, d,
                         {line, risePulse, fallPulse, multiLow, heldLow, lowOwner},
                         {mLine, mRise, mFall, mMulti, mHeld, mOwner});
            end
        end
    endtask

`ifdef PULLUP_STATS_EN
    task automatic test_stats();
        int lens[3] = '{5, 12, 7};
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);
        foreach (lens[k]) begin
            for (int i = 0; i < lens[k] - (RISE - 1); i++) step(4'b0010, 1'b0);
            for (int i = 0; i < RISE + 1; i++) step(4'b0000, 1'b0);
        end
        nCompared++;
        if ({fallCount, maxLow} !== {16'd3, 16'd12} || maxLow !== 16'(mMaxLow)) begin
            nMismatched++;
            $display("[TB] FAIL stats got=%0d/%0d want=3/12 (model %0d/%0d)",
                     fallCount, maxLow, mFallCnt, mMaxLow);
        end
        step(4'b0000, 1'b1);
        nCompared++;
        if ({fallCount, maxLow} !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL stats_reset got=%0d/%0d want=0/0", fallCount, maxLow);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_pulse();
        test_interrupted_rise();
        test_multi_low();
        test_hold();
        test_random();
`ifdef PULLUP_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
